// File: rtl/timer_ctrl_if.sv
// Control/status bundle between a host FSM and timer_ctrl.
// The host drives start/stop and run parameters; the timer reports count and status.
interface timer_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
);
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic [PRE_W-1:0] presc;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tick;

  modport master (
    output start, stop, mode, period, presc,
    input  count, busy, done, tick
  );

  modport slave (
    input  start, stop, mode, period, presc,
    output count, busy, done, tick
  );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable start/stop timer around a WIDTH-bit up-counter: one-shot or auto-reload,
// terminal-count tick. Prescaler is built only when TIMER_CTRL_PRESCALE_EN is defined.
module timer_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  timer_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             step;

`ifdef TIMER_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] n_q, n_d;

  assign step = (pre_q == n_q);

  // Prescaler restarts on every start/stop so a run always begins a full N+1 window.
  always_comb begin
    pre_d = pre_q;
    n_d   = n_q;
    if (bus.stop) begin
      pre_d = '0;
    end else if (bus.start) begin
      pre_d = '0;
      n_d   = bus.presc;
    end else if (state_q == RUN) begin
      pre_d = step ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      n_q   <= '0;
    end else begin
      pre_q <= pre_d;
      n_q   <= n_d;
    end
  end
`else
  logic unused_presc;
  assign unused_presc = ^bus.presc;
  assign step         = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    p_d     = p_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (bus.start) begin
      state_d = RUN;
      count_d = '0;
      p_d     = bus.period;
      mode_d  = bus.mode;
    end else begin
      unique case (state_q)
        IDLE: count_d = '0;
        RUN: begin
          if (step) begin
            if (count_q == p_q) begin
              tick_d = 1'b1;
              if (mode_q) count_d = '0;
              else        state_d = DONE;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      p_q     <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_q     <= p_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed and randomized bench for timer_ctrl; expected outputs come from an
// elapsed-time model (edges since start) rather than a cycle-level state machine.
module tb_timer_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Reference model: active run, edges elapsed since the start edge, latched params.
  bit   m_active = 1'b0;
  int   m_t = 0;
  int   m_p = 0;
  int   m_n = 0;
  bit   m_mode = 1'b0;

  timer_ctrl_if #(.WIDTH(4), .PRE_W(4)) bus ();
  timer_ctrl #(.WIDTH(4), .PRE_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic int neff(input logic [3:0] p);
`ifdef TIMER_CTRL_PRESCALE_EN
    return int'(p);
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int T, k, e_cnt;
    bit e_tick, e_busy, e_done;
    e_cnt = 0; e_tick = 0; e_busy = 0; e_done = 0;
    if (m_active) begin
      T = (m_p + 1) * (m_n + 1);
      k = m_t / (m_n + 1);
      if (m_mode) begin
        e_cnt  = k % (m_p + 1);
        e_tick = (m_t > 0) && (m_t % T == 0);
        e_busy = 1;
      end else begin
        e_cnt  = (k > m_p) ? m_p : k;
        e_tick = (m_t == T);
        e_busy = (m_t < T);
        e_done = (m_t >= T);
      end
    end
    chk({tag, ".count"}, bus.count, e_cnt);
    chk({tag, ".tick"},  bus.tick,  e_tick);
    chk({tag, ".busy"},  bus.busy,  e_busy);
    chk({tag, ".done"},  bus.done,  e_done);
  endtask

  // One clock edge: advance the model from the inputs sampled there, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    if (bus.stop) m_active = 1'b0;
    else if (bus.start) begin
      m_active = 1'b1; m_t = 0;
      m_p = int'(bus.period); m_n = neff(bus.presc); m_mode = bus.mode;
    end else if (m_active) m_t++;
    #1;
    check_model(tag);
  endtask

  task automatic drive(input bit s, input bit p, input bit m, input int per, input int pre);
    bus.start  = s;
    bus.stop   = p;
    bus.mode   = m;
    bus.period = per[3:0];
    bus.presc  = pre[3:0];
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    #1;
    chk("reset.count", bus.count, 0);
    chk("reset.busy",  bus.busy,  0);
    chk("reset.done",  bus.done,  0);
    chk("reset.tick",  bus.tick,  0);
    @(negedge clk);
    rst = 1'b0;

    // One-shot P=3 N=0
    drive(1, 0, 0, 3, 0);
    step("os");
    drive(0, 0, 1, 9, 5);  // mid-run parameter changes must be ignored
    for (int i = 0; i < 4; i++) step("os");
    chk("os_tick", bus.tick, 1);
    chk("os_done", bus.done, 1);
    chk("os_cnt",  bus.count, 3);
    for (int i = 0; i < 3; i++) step("os_hold");
    chk("os_hold_tick", bus.tick, 0);

    // Auto-reload P=2 N=1
    drive(1, 0, 1, 2, 1);
    step("ar");
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) step("ar");

    // P=0 auto-reload: tick every cycle
    drive(1, 0, 1, 0, 0);
    step("p0");
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("p0");
      chk("p0_tick", bus.tick, 1);
    end

    // P=15 wrap
    drive(1, 0, 1, 15, 0);
    step("p15");
    drive(0, 0, 1, 15, 0);
    for (int i = 0; i < 20; i++) step("p15");

    // Stop on the terminal edge
    drive(1, 0, 1, 1, 0);
    step("stop");
    drive(0, 0, 1, 1, 0);
    step("stop");
    drive(0, 1, 1, 1, 0);
    step("stop");
    chk("stop_tick", bus.tick, 0);
    chk("stop_busy", bus.busy, 0);
    chk("stop_cnt",  bus.count, 0);
    drive(1, 1, 1, 4, 0);
    step("both");
    chk("both_busy", bus.busy, 0);
    drive(0, 0, 0, 0, 0);
    step("both");

    // Restart mid-run with new P=5, N=7
    drive(1, 0, 1, 9, 0);
    step("rs");
    drive(0, 0, 1, 9, 0);
    for (int i = 0; i < 3; i++) step("rs");
    drive(1, 0, 1, 5, 7);
    step("rs");
    chk("rs_cnt", bus.count, 0);
    drive(0, 0, 1, 5, 7);
    for (int i = 0; i < 66; i++) step("rs");

    // Asynchronous reset mid-run
    drive(1, 0, 1, 9, 0);
    step("rst");
    drive(0, 0, 1, 9, 0);
    for (int i = 0; i < 5; i++) step("rst");
    #3 rst = 1'b1;
    #1;
    chk("arst.count", bus.count, 0);
    chk("arst.busy",  bus.busy,  0);
    chk("arst.done",  bus.done,  0);
    chk("arst.tick",  bus.tick,  0);
    m_active = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step("post_rst");

    // Randomized traffic, inputs wiggled every cycle
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
